aes_key_schedule: RTL and testbench

Parametrised AES key-expansion engine: the successor to the single-round, AES-128-only round-key generator. On a `load` strobe it expands a 128/192/256-bit cipher key into the full FIPS-197 schedule of Nr+1 round keys, one 32-bit word at a time. It buffers the schedule in an internal word store and serves any round key through a registered read port. It sits between the key input interface and the AES round datapath, which indexes round keys by round number instead of regenerating them.

---
 rtl/aes_pkg.sv | 27 ++
 rtl/sbox_word_sync.sv | 40 ++++
 rtl/aes_key_schedule.sv | 140 ++++++++++++++
 tb/tb_aes_key_schedule.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) doubling, word rotation, round count and the
// key-schedule state encoding.
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        KS_IDLE,
        KS_SUB,
        KS_WRITE,
        KS_DONE
    } ks_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic int nr_of(input int nk);
        return nk + 6;
    endfunction

endpackage

// File: rtl/sbox_word_sync.sv
// Four AES byte S-boxes on one 32-bit word with a registered output
// (1-cycle latency); shared between key expansion and the cipher datapath.
module sbox_word_sync (
    input  logic        clk,
    input  logic [31:0] data_i,
    output logic [31:0] data_o
);

    // Byte 0x00 maps to the most significant byte of this constant.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] top;
        top = {~b, 3'b111};
        return SBOX_FLAT[top -: 8];
    endfunction

    always_ff @(posedge clk) begin
        data_o <= {sub_byte(data_i[31:24]), sub_byte(data_i[23:16]),
                   sub_byte(data_i[15:8]),  sub_byte(data_i[7:0])};
    end

endmodule

// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion into an internal word store, one word per two
// cycles, with a registered round-key read port.
module aes_key_schedule
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [32*NK-1:0] key,
    input  logic [3:0]       rd_round,
    output logic [127:0]     rd_key,
    output logic             busy,
    output logic             done
);

    localparam int         NR        = nr_of(NK);
    localparam int         NW        = 4 * (NR + 1);
    localparam int         KIW       = $clog2(NK);
    localparam logic [5:0] NK_W      = 6'(NK);
    localparam logic [5:0] LAST_W    = 6'(NW - 1);
    localparam logic [2:0] KMOD_LAST = 3'(NK - 1);
    localparam logic [3:0] NR_R      = 4'(NR);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_key_schedule: NK must be 4, 6 or 8");
    end

    ks_state_t    state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [2:0]   kmod_q, kmod_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [127:0] rd_key_q, rd_key_d;
    logic [31:0]  store_q [NW];
    logic [31:0]  key_words [NK];

    logic         wr_en;
    logic         rot_step, sub_step;
    logic [5:0]   prev_idx, back_idx, rd_idx;
    logic [31:0]  prev_word, back_word, sbox_in, sbox_out, temp_word, new_word;

    for (genvar g = 0; g < NK; g++) begin : g_key_words
        assign key_words[g] = key[32*(NK-1-g) +: 32];
    end

    sbox_word_sync u_sbox (
        .clk    (clk),
        .data_i (sbox_in),
        .data_o (sbox_out)
    );

    // kmod tracks i mod NK so no divider is needed.
    always_comb begin
        prev_idx  = idx_q - 6'd1;
        back_idx  = idx_q - NK_W;
        prev_word = store_q[prev_idx];
        back_word = store_q[back_idx];
        rot_step  = (kmod_q == 3'd0);
        sub_step  = (NK == 8) && (kmod_q == 3'd4);
        sbox_in   = rot_step ? rot_word(prev_word) : prev_word;
        if (rot_step) begin
            temp_word = sbox_out ^ {rcon_q, 24'h0};
        end else if (sub_step) begin
            temp_word = sbox_out;
        end else begin
            temp_word = prev_word;
        end
        new_word = back_word ^ temp_word;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        kmod_d  = kmod_q;
        rcon_d  = rcon_q;
        wr_en   = 1'b0;
        if (load) begin
            state_d = KS_SUB;
            idx_d   = NK_W;
            kmod_d  = 3'd0;
            rcon_d  = RCON_INIT;
        end else begin
            case (state_q)
                KS_SUB: state_d = KS_WRITE;
                KS_WRITE: begin
                    wr_en  = 1'b1;
                    idx_d  = idx_q + 6'd1;
                    kmod_d = (kmod_q == KMOD_LAST) ? 3'd0 : kmod_q + 3'd1;
                    if (rot_step) begin
                        rcon_d = xtime(rcon_q);
                    end
                    state_d = (idx_q == LAST_W) ? KS_DONE : KS_SUB;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_idx   = {rd_round, 2'b00};
        rd_key_d = '0;
        if (rd_round <= NR_R) begin
            rd_key_d = {store_q[rd_idx], store_q[rd_idx + 6'd1],
                        store_q[rd_idx + 6'd2], store_q[rd_idx + 6'd3]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= KS_IDLE;
            idx_q    <= '0;
            kmod_q   <= '0;
            rcon_q   <= RCON_INIT;
            rd_key_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            kmod_q   <= kmod_d;
            rcon_q   <= rcon_d;
            rd_key_q <= rd_key_d;
        end
    end

    // The store is deliberately left out of reset; only a load defines it.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < NK; k++) begin
                store_q[6'(k)] <= key_words[KIW'(k)];
            end
        end else if (wr_en) begin
            store_q[idx_q] <= new_word;
        end
    end

    assign rd_key = rd_key_q;
    assign busy   = (state_q == KS_SUB) || (state_q == KS_WRITE);
    assign done   = (state_q == KS_DONE);

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule with NK=4, 6 and 8 instances checked
// against an algebraic FIPS-197 key-expansion model.
module tb_aes_key_schedule;

    localparam logic [127:0] KEY128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R1_128    = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R12_192   = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R14_256   = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] R10_ZERO  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         load [3];
    logic [255:0] keyIn [3];
    logic [3:0]   rdRound [3];
    logic [127:0] rdKey [3];
    logic         busyOut [3];
    logic         doneOut [3];

    int compared = 0;
    int mismatched = 0;

    logic [7:0]   sboxModel [256];
    logic [31:0]  modelW [3][60];
    logic         modelActive [3];
    int           modelEdges [3];
    logic         modelDone [3];
    logic         rdExpValid [3];
    logic [127:0] rdExp [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GNK = 4 + 2 * g;
        aes_key_schedule #(.NK(GNK)) dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .load     (load[g]),
            .key      (keyIn[g][32*GNK-1:0]),
            .rd_round (rdRound[g]),
            .rd_key   (rdKey[g]),
            .busy     (busyOut[g]),
            .done     (doneOut[g])
        );
    end

    function automatic int nkOf(input int d);
        return 4 + 2 * d;
    endfunction

    function automatic int nrOf(input int d);
        return nkOf(d) + 6;
    endfunction

    function automatic int nwOf(input int d);
        return 4 * (nrOf(d) + 1);
    endfunction

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int n = 0; n < 8; n++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sboxCalc(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        if (v == 8'h00) begin
            inv = 8'h00;
        end else begin
            for (int n = 0; n < 254; n++) inv = gfMul(inv, v);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subWordModel(input logic [31:0] w);
        return {sboxModel[w[31:24]], sboxModel[w[23:16]],
                sboxModel[w[15:8]],  sboxModel[w[7:0]]};
    endfunction

    function automatic logic [127:0] modelRound(input int d, input int r);
        return {modelW[d][4*r], modelW[d][4*r+1], modelW[d][4*r+2], modelW[d][4*r+3]};
    endfunction

    task automatic expandModel(input int d, input logic [255:0] k);
        int nk = nkOf(d);
        logic [7:0] rcon = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) modelW[d][i] = k[32*(nk-1-i) +: 32];
        for (int i = nk; i < nwOf(d); i++) begin
            t = modelW[d][i-1];
            if (i % nk == 0) begin
                t = subWordModel({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gfMul(rcon, 8'h02);
            end else if (nk == 8 && i % 8 == 4) begin
                t = subWordModel(t);
            end
            modelW[d][i] = modelW[d][i-nk] ^ t;
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Cycle-level model: counts edges since load, predicts busy/done and the
    // registered read value from the schedule as it stood before each edge.
    always @(posedge clk or negedge reset_n) begin
        for (int d = 0; d < 3; d++) begin
            if (!reset_n) begin
                modelActive[d] <= 1'b0;
                modelEdges[d]  <= 0;
                modelDone[d]   <= 1'b0;
                rdExpValid[d]  <= 1'b1;
                rdExp[d]       <= '0;
            end else begin
                if (int'(rdRound[d]) > nrOf(d)) begin
                    rdExpValid[d] <= 1'b1;
                    rdExp[d]      <= '0;
                end else if (modelDone[d]) begin
                    rdExpValid[d] <= 1'b1;
                    rdExp[d]      <= modelRound(d, int'(rdRound[d]));
                end else begin
                    rdExpValid[d] <= 1'b0;
                end
                if (load[d]) begin
                    expandModel(d, keyIn[d]);
                    modelActive[d] <= 1'b1;
                    modelEdges[d]  <= 0;
                    modelDone[d]   <= 1'b0;
                end else if (modelActive[d] && !modelDone[d]) begin
                    modelEdges[d] <= modelEdges[d] + 1;
                    if (modelEdges[d] + 1 == 2 * (nwOf(d) - nkOf(d))) modelDone[d] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("dut%0d busy", d), 128'(busyOut[d]),
                        128'(modelActive[d] && !modelDone[d]));
            checkOutput($sformatf("dut%0d done", d), 128'(doneOut[d]), 128'(modelDone[d]));
            if (rdExpValid[d]) begin
                checkOutput($sformatf("dut%0d rd_key", d), rdKey[d], rdExp[d]);
            end
        end
    end

    task automatic applyStimulus(input int d, input logic [255:0] k);
        @(negedge clk);
        load[d]  = 1'b1;
        keyIn[d] = k;
        @(negedge clk);
        load[d]  = 1'b0;
    endtask

    task automatic waitDone(input int d, input int expCycles);
        int n = 0;
        while (doneOut[d] !== 1'b1 && n < expCycles + 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput($sformatf("dut%0d done latency", d), 128'(n), 128'(expCycles));
    endtask

    task automatic readRound(input int d, input int r, input logic [127:0] expected);
        @(negedge clk);
        rdRound[d] = 4'(r);
        @(posedge clk);
        #1;
        checkOutput($sformatf("dut%0d round %0d", d, r), rdKey[d], expected);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int v = 0; v < 256; v++) sboxModel[v] = sboxCalc(8'(v));
        reset_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            load[d]    = 1'b0;
            keyIn[d]   = '0;
            rdRound[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("dut%0d reset busy", d), 128'(busyOut[d]), 128'(0));
            checkOutput($sformatf("dut%0d reset done", d), 128'(doneOut[d]), 128'(0));
            checkOutput($sformatf("dut%0d reset rd_key", d), rdKey[d], 128'h0);
        end
        checkOutput("model sbox 53", 128'(sboxModel[8'h53]), 128'(8'hed));
        reset_n = 1'b1;

        $display("[TB] NK=4 FIPS-197 key");
        applyStimulus(0, 256'(KEY128));
        checkOutput("busy after load", 128'(busyOut[0]), 128'(1));
        waitDone(0, 80);
        checkOutput("model nk4 round 10", modelRound(0, 10), R10_128);
        readRound(0, 1, R1_128);
        readRound(0, 10, R10_128);
        readRound(0, 0, KEY128);
        readRound(0, 11, 128'h0);
        readRound(0, 15, 128'h0);
        for (int r = 0; r <= 10; r++) begin
            @(negedge clk);
            rdRound[0] = 4'(r);
            @(posedge clk);
            #1;
            checkOutput($sformatf("step round %0d", r), rdKey[0], modelRound(0, r));
        end

        $display("[TB] NK=6 and NK=8 keys");
        applyStimulus(1, 256'(KEY192));
        waitDone(1, 92);
        checkOutput("model nk6 round 12", modelRound(1, 12), R12_192);
        readRound(1, 12, R12_192);
        applyStimulus(2, KEY256);
        waitDone(2, 104);
        checkOutput("model nk8 round 14", modelRound(2, 14), R14_256);
        readRound(2, 14, R14_256);
        readRound(2, 15, 128'h0);

        $display("[TB] restart with zero key mid-expansion");
        applyStimulus(0, 256'(KEY128));
        repeat (29) @(negedge clk);
        applyStimulus(0, 256'h0);
        waitDone(0, 80);
        readRound(0, 10, R10_ZERO);
        readRound(0, 0, 128'h0);

        $display("[TB] load on the final write edge");
        applyStimulus(0, 256'h0);
        repeat (78) @(negedge clk);
        applyStimulus(0, 256'(KEY128));
        checkOutput("collision done", 128'(doneOut[0]), 128'(0));
        checkOutput("collision busy", 128'(busyOut[0]), 128'(1));
        waitDone(0, 80);
        readRound(0, 10, R10_128);

        $display("[TB] asynchronous reset mid-expansion");
        @(negedge clk);
        rdRound[0] = 4'd1;
        applyStimulus(0, 256'(KEY128));
        repeat (39) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset busy", 128'(busyOut[0]), 128'(0));
        checkOutput("async reset done", 128'(doneOut[0]), 128'(0));
        checkOutput("async reset rd_key", rdKey[0], 128'h0);
        checkOutput("async reset done nk6", 128'(doneOut[1]), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(0, 256'(KEY128));
        waitDone(0, 80);
        readRound(0, 10, R10_128);
        readRound(0, 1, R1_128);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
